// File: rtl/sram_blwl_pkg.sv
// Shared definitions for the sram_blwl bank programming controller.
//   - state encoding of the programming FSM
//   - one-hot word-line decode
//   - small constant helper for sizing the phase timer
package sram_blwl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_SETUP = 3'd2;
  localparam state_t ST_PULSE = 3'd3;
  localparam state_t ST_HOLD  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Widest word-line bus the decode supports; callers cast down to NUM_WL.
  localparam int OH_MAX   = 64;
  localparam int OH_IDX_W = 6;

  function automatic logic [OH_MAX-1:0] onehot(input logic [OH_IDX_W-1:0] idx);
    logic [OH_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_blwl_timer.sv
// Loadable down-counter with zero flag, shared by the SETUP, PULSE and HOLD
// phases of the programming sequence.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (has priority over en)
//   load_val   : phase length minus one
//   en         : count down by one (saturates at zero)
//   zero       : counter is at zero, i.e. the current phase ends this cycle
module sram_blwl_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_blwl_bank_prog.sv
// Programming controller for a bank of sram6T_blwl configuration cells.
// Accepts one row word per din_valid/din_ready transfer and drives the bank
// with a setup / word-line pulse / hold sequence; the cells latch bl on the
// rising edge of their wl. One pass programs rows 0..NUM_WL-1, then done.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a pass (only honoured in IDLE or DONE)
//   din        : row data word
//   din_valid  : din holds a valid row word
//   din_ready  : controller accepts a row word this cycle (LOAD state)
//   bl         : registered bit-line drive
//   wl         : registered word-line drive, one-hot or zero
//   busy       : pass in progress
//   done       : sticky pass-complete flag, cleared by start
module sram_blwl_bank_prog #(
  parameter int NUM_BL    = 8,
  parameter int NUM_WL    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_BL-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [NUM_BL-1:0] bl,
  output logic [NUM_WL-1:0] wl,
  output logic              busy,
  output logic              done
);
  import sram_blwl_pkg::*;

  localparam int MAX_CYC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int RW      = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic              done_d;
  logic [NUM_BL-1:0] bl_d;
  logic [NUM_WL-1:0] wl_d;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0]     tmr_val;
  logic              last_row;

  assign last_row = (row_q == RW'(NUM_WL - 1));

  sram_blwl_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start)     state_d = ST_LOAD;
      ST_LOAD:          if (din_valid) state_d = ST_SETUP;
      ST_SETUP:         if (tmr_zero)  state_d = ST_PULSE;
      ST_PULSE:         if (tmr_zero)  state_d = ST_HOLD;
      ST_HOLD:          if (tmr_zero)  state_d = last_row ? ST_DONE : ST_LOAD;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Output / datapath decode. bl and wl are registered from bl_d / wl_d so
  // the word lines reach the bank glitch-free.
  always_comb begin
    din_ready = (state_q == ST_LOAD);
    busy      = (state_q == ST_LOAD) || (state_q == ST_SETUP) ||
                (state_q == ST_PULSE) || (state_q == ST_HOLD);
    row_d     = row_q;
    done_d    = done;
    bl_d      = bl;
    wl_d      = wl;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          row_d  = '0;
          done_d = 1'b0;
        end
      end
      ST_LOAD: begin
        bl_d = '0;
        wl_d = '0;
        if (din_valid) begin
          bl_d     = din;
          tmr_load = 1'b1;
          tmr_val  = TW'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          wl_d     = NUM_WL'(onehot(OH_IDX_W'(row_q)));
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYC - 1);
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          wl_d     = '0;
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD_CYC - 1);
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          bl_d = '0;
          // Row counter stops at NUM_WL-1; the last row ends the pass instead.
          if (last_row) done_d = 1'b1;
          else          row_d  = row_q + RW'(1);
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      done  <= 1'b0;
      bl    <= '0;
      wl    <= '0;
    end else begin
      row_q <= row_d;
      done  <= done_d;
      bl    <= bl_d;
      wl    <= wl_d;
    end
  end

endmodule
